// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS-subset controller.
package mc_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    EXEC_R   = 4'd3,
    WB_R     = 4'd4,
    EXEC_I   = 4'd5,
    WB_I     = 4'd6,
    MEM_ADDR = 4'd7,
    MEM_RD   = 4'd8,
    WB_MEM   = 4'd9,
    MEM_WR   = 4'd10,
    BRANCH   = 4'd11,
    JUMP     = 4'd12,
    TRAP     = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_OR    = 3'b010;
  localparam logic [2:0] ALU_FUNCT = 3'b100;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic is_mem_state(state_t s);
    return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait counter; flags a timeout when the limit is hit
// with no ack in the same cycle.
module mc_wait_timer #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic req,
  input  logic ack,
  output logic timeout
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_WAIT_MAX - 1);

  logic [CNT_W-1:0] cnt;

  // timeout fires on the stall that would take the count to the limit
  assign timeout = req & ~ack & (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (req & ~ack) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore main controller for the multi-cycle MIPS-subset CPU.
// Optional perf counters via MC_PERF_CNT_EN.
module multicycle_control
  import mc_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  OP,
  input  logic        zero,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_write,
  output logic        IorD,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic [1:0]  pc_source,
  output logic        ALUsrcA,
  output logic [1:0]  ALUsrcB,
  output logic [2:0]  ALUop,
  output logic        extop,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        fault,
  output logic [3:0]  state
`ifdef MC_PERF_CNT_EN
  ,
  output logic [31:0] cyc_cnt,
  output logic [31:0] instr_cnt
`endif
);

  state_t cur, nxt;
  logic   timeout;
  logic   clr;
  logic   zero_unused;

  // zero is consumed by the datapath through pc_write_cond
  assign zero_unused = zero;
  assign state = cur;
  assign clr = is_mem_state(nxt) && (nxt != cur);

  mc_wait_timer #(
    .MEM_WAIT_MAX(MEM_WAIT_MAX),
    .CNT_W(CNT_W)
  ) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .clr(clr),
    .req(mem_req),
    .ack(mem_ack),
    .timeout(timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur <= IDLE;
    else        cur <= nxt;
  end

  always_comb begin
    nxt = cur;
    unique case (cur)
      IDLE:   nxt = FETCH;
      FETCH: begin
        if (mem_ack)      nxt = DECODE;
        else if (timeout) nxt = TRAP;
      end
      DECODE: begin
        unique case (1'b1)
          (OP == OP_RTYPE):               nxt = EXEC_R;
          (OP == OP_ORI):                 nxt = EXEC_I;
          (OP == OP_LW) || (OP == OP_SW): nxt = MEM_ADDR;
          (OP == OP_BEQ):                 nxt = BRANCH;
          (OP == OP_J):                   nxt = JUMP;
          default:                        nxt = TRAP;
        endcase
      end
      EXEC_R:   nxt = WB_R;
      WB_R:     nxt = FETCH;
      EXEC_I:   nxt = WB_I;
      WB_I:     nxt = FETCH;
      MEM_ADDR: nxt = (OP == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD: begin
        if (mem_ack)      nxt = WB_MEM;
        else if (timeout) nxt = TRAP;
      end
      WB_MEM:   nxt = FETCH;
      MEM_WR: begin
        if (mem_ack)      nxt = FETCH;
        else if (timeout) nxt = TRAP;
      end
      BRANCH:   nxt = FETCH;
      JUMP:     nxt = FETCH;
      default:  nxt = TRAP;
    endcase
  end

  always_comb begin
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    IorD          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = PCSRC_ALU;
    ALUsrcA       = 1'b0;
    ALUsrcB       = SRCB_RT;
    ALUop         = ALU_ADD;
    extop         = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    fault         = 1'b0;
    unique case (cur)
      FETCH: begin
        mem_req  = 1'b1;
        ir_write = 1'b1;
        pc_write = 1'b1;
        ALUsrcB  = SRCB_FOUR;
      end
      DECODE: begin
        ALUsrcB = SRCB_IMM_SH;
        extop   = 1'b1;
      end
      EXEC_R: begin
        ALUsrcA = 1'b1;
        ALUop   = ALU_FUNCT;
      end
      WB_R: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      EXEC_I: begin
        ALUsrcA = 1'b1;
        ALUsrcB = SRCB_IMM;
        ALUop   = ALU_OR;
      end
      WB_I: reg_write = 1'b1;
      MEM_ADDR: begin
        ALUsrcA = 1'b1;
        ALUsrcB = SRCB_IMM;
        extop   = 1'b1;
      end
      MEM_RD: begin
        mem_req = 1'b1;
        IorD    = 1'b1;
      end
      WB_MEM: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      MEM_WR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        IorD      = 1'b1;
      end
      BRANCH: begin
        ALUsrcA       = 1'b1;
        ALUop         = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
      end
      TRAP:    fault = 1'b1;
      default: ;
    endcase
  end

`ifdef MC_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt   <= '0;
      instr_cnt <= '0;
    end else begin
      if (cur != IDLE && cur != TRAP)
        cyc_cnt <= cyc_cnt + 32'd1;
      if (nxt == FETCH && cur != FETCH && cur != IDLE)
        instr_cnt <= instr_cnt + 32'd1;
    end
  end
`else
  // perf counters not built
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed scoreboard bench for multicycle_control.
// Covers perf counters when MC_PERF_CNT_EN is defined.
module tb_multicycle_control;
  import mc_pkg::*;

  typedef logic [22:0] snap_t;

  logic       clk;
  logic       rst_n;
  logic [5:0] OP;
  logic       zero;
  logic       mem_ack;
  logic       mem_req, mem_write, IorD, ir_write, pc_write;
  logic       pc_write_cond, ALUsrcA, extop, reg_write;
  logic       reg_dst, mem_to_reg, fault;
  logic [1:0] pc_source, ALUsrcB;
  logic [2:0] ALUop;
  logic [3:0] state;
`ifdef MC_PERF_CNT_EN
  logic [31:0] cyc_cnt, instr_cnt;
`endif

  int checks = 0;
  int errors = 0;
  snap_t sb[$];
  snap_t obs;

  multicycle_control dut (
    .clk(clk),
    .rst_n(rst_n),
    .OP(OP),
    .zero(zero),
    .mem_ack(mem_ack),
    .mem_req(mem_req),
    .mem_write(mem_write),
    .IorD(IorD),
    .ir_write(ir_write),
    .pc_write(pc_write),
    .pc_write_cond(pc_write_cond),
    .pc_source(pc_source),
    .ALUsrcA(ALUsrcA),
    .ALUsrcB(ALUsrcB),
    .ALUop(ALUop),
    .extop(extop),
    .reg_write(reg_write),
    .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg),
    .fault(fault),
    .state(state)
`ifdef MC_PERF_CNT_EN
    ,
    .cyc_cnt(cyc_cnt),
    .instr_cnt(instr_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {state, mem_req, mem_write, IorD, ir_write,
                pc_write, pc_write_cond, pc_source, ALUsrcA,
                ALUsrcB, ALUop, extop, reg_write, reg_dst,
                mem_to_reg, fault};

  function automatic snap_t model(state_t s);
    logic mr, mw, iord, irw, pcw, pcwc, sa, ext;
    logic rw, rd, m2r, flt;
    logic [1:0] pcs, sb_;
    logic [2:0] aop;
    {mr, mw, iord, irw, pcw, pcwc, sa, ext} = '0;
    {rw, rd, m2r, flt} = '0;
    pcs = 2'b00;
    sb_ = 2'b00;
    aop = 3'b000;
    case (s)
      FETCH:    begin mr = 1; irw = 1; pcw = 1; sb_ = 2'b01; end
      DECODE:   begin sb_ = 2'b11; ext = 1; end
      EXEC_R:   begin sa = 1; aop = 3'b100; end
      WB_R:     begin rd = 1; rw = 1; end
      EXEC_I:   begin sa = 1; sb_ = 2'b10; aop = 3'b010; end
      WB_I:     rw = 1;
      MEM_ADDR: begin sa = 1; sb_ = 2'b10; ext = 1; end
      MEM_RD:   begin mr = 1; iord = 1; end
      WB_MEM:   begin m2r = 1; rw = 1; end
      MEM_WR:   begin mr = 1; mw = 1; iord = 1; end
      BRANCH:   begin sa = 1; aop = 3'b001; pcwc = 1; pcs = 2'b01; end
      JUMP:     begin pcw = 1; pcs = 2'b10; end
      TRAP:     flt = 1;
      default:  ;
    endcase
    return {4'(s), mr, mw, iord, irw, pcw, pcwc, pcs, sa,
            sb_, aop, ext, rw, rd, m2r, flt};
  endfunction

  task automatic compare(input string tag);
    snap_t e;
    e = sb.pop_front();
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, e);
    end
  endtask

  task automatic step(input state_t s, input string tag);
    sb.push_back(model(s));
    @(negedge clk);
    compare(tag);
  endtask

  task automatic chk_now(input state_t s, input string tag);
    sb.push_back(model(s));
    #1;
    compare(tag);
  endtask

  initial begin
    rst_n   = 1'b0;
    OP      = OP_RTYPE;
    zero    = 1'b0;
    mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk_now(IDLE, "reset");

    // R-type, zero-wait memory
    @(negedge clk);
    mem_ack = 1'b1;
    rst_n   = 1'b1;
    step(FETCH, "r_fetch");
    step(DECODE, "r_decode");
    step(EXEC_R, "r_exec");
    step(WB_R, "r_wb");
    step(FETCH, "r_done");

    // LW with a stalled read
    OP = OP_LW;
    step(DECODE, "lw_decode");
    step(MEM_ADDR, "lw_addr");
    mem_ack = 1'b0;
    repeat (4) step(MEM_RD, "lw_rd_wait");
    mem_ack = 1'b1;
    step(WB_MEM, "lw_wb");
    step(FETCH, "lw_done");

    OP = OP_SW;
    step(DECODE, "sw_decode");
    step(MEM_ADDR, "sw_addr");
    step(MEM_WR, "sw_wr");
    step(FETCH, "sw_done");

    OP = OP_BEQ;
    zero = 1'b1;
    step(DECODE, "beq_decode");
    step(BRANCH, "beq_branch");
    step(FETCH, "beq_done");

    OP = OP_J;
    step(DECODE, "j_decode");
    step(JUMP, "j_jump");
    step(FETCH, "j_done");

    OP = OP_ORI;
    step(DECODE, "ori_decode");
    step(EXEC_I, "ori_exec");
    step(WB_I, "ori_wb");
    step(FETCH, "ori_done");

    // illegal opcode traps and stays there
    OP = 6'b111111;
    step(DECODE, "ill_decode");
    step(TRAP, "ill_trap");
    mem_ack = 1'b0;
    step(TRAP, "trap_hold0");
    OP = OP_RTYPE;
    mem_ack = 1'b1;
    step(TRAP, "trap_hold1");

    rst_n = 1'b0;
    chk_now(IDLE, "rst_clears_fault");

    // fetch timeout
    @(negedge clk);
    mem_ack = 1'b0;
    rst_n   = 1'b1;
    repeat (15) step(FETCH, "to_wait");
    step(TRAP, "timeout");

    // ack on the limit cycle wins
    rst_n = 1'b0;
    chk_now(IDLE, "rst2");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) step(FETCH, "late_wait");
    mem_ack = 1'b1;
    OP = OP_J;
    step(DECODE, "late_ack");
    step(JUMP, "late_jump");
    step(FETCH, "late_done");

`ifdef MC_PERF_CNT_EN
    rst_n = 1'b0;
    chk_now(IDLE, "rst_perf");
    checks++;
    assert (cyc_cnt === 32'd0 && instr_cnt === 32'd0) else begin
      errors++;
      $error("FAIL perf_reset: observed %0d/%0d expected 0/0",
             cyc_cnt, instr_cnt);
    end
    @(negedge clk);
    OP    = OP_ORI;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(FETCH, "perf_fetch");
      step(DECODE, "perf_decode");
      step(EXEC_I, "perf_exec");
      step(WB_I, "perf_wb");
    end
    step(FETCH, "perf_fetch4");
    checks++;
    assert (instr_cnt === 32'd3) else begin
      errors++;
      $error("FAIL instr_cnt: observed %0d expected 3", instr_cnt);
    end
    checks++;
    assert (cyc_cnt === 32'd12) else begin
      errors++;
      $error("FAIL cyc_cnt: observed %0d expected 12", cyc_cnt);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle main controller for the MIPS-subset CPU: R-type, ORI, LW, SW, BEQ, J.
- Sequences the shared datapath (one memory port, one ALU) across several cycles per instruction, replacing the single-cycle opcode decoder.
- Adds a memory ready/ack handshake with a timeout, plus an illegal-opcode/fault trap.

Parameters:
- MEM_WAIT_MAX, 15, maximum wait cycles for mem_ack before fault (1..255).
- CNT_W, 8, width of the wait counter; must hold MEM_WAIT_MAX.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- OP  in  6  opcode field from the instruction register.
- zero  in  1  ALU zero flag.
- mem_ack  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request valid.
- mem_write  out  1  request is a write (qualified by mem_req).
- IorD  out  1  0 = PC address, 1 = ALUOut address.
- ir_write  out  1  load the instruction register.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if zero (BEQ).
- pc_source  out  2  00 = ALU, 01 = ALUOut, 10 = jump target.
- ALUsrcA  out  1  0 = PC, 1 = rs.
- ALUsrcB  out  2  00 = rt, 01 = const 4, 10 = ext imm, 11 = ext imm<<2.
- ALUop  out  3  000 = add, 001 = sub, 010 = or, 1xx = use funct.
- extop  out  1  1 = sign-extend, 0 = zero-extend.
- reg_write  out  1  register file write.
- reg_dst  out  1  1 = rd, 0 = rt.
- mem_to_reg  out  1  1 = MDR, 0 = ALUOut.
- fault  out  1  sticky; set on illegal opcode or memory timeout.
- state  out  4  current state, for debug.

Behaviour:
- Moore FSM. All outputs decode from the state register only, with no OP/zero/mem_ack combinational path to any output.
- Any output not listed for a state is 0.
- Reset: state = IDLE, all outputs 0, fault = 0, wait counter = 0. Reset mid-instruction aborts it with no further writes.
- IDLE -> FETCH unconditionally.
- FETCH:
  - Outputs: mem_req = 1, IorD = 0, ALUsrcA = 0, ALUsrcB = 01, ALUop = 000, pc_source = 00.
  - On mem_ack: ir_write and pc_write assert in the same (ack) cycle; go to DECODE.
  - The controller therefore drives ir_write = pc_write = mem_req in FETCH, and the datapath gates them with mem_ack. This is documented interface semantics.
- DECODE:
  - Outputs: ALUsrcA = 0, ALUsrcB = 11, ALUop = 000, extop = 1 (branch target precompute).
  - Dispatch on OP: 000000 -> EXEC_R; 001101 -> EXEC_I; 100011 or 101011 -> MEM_ADDR; 000100 -> BRANCH; 000010 -> JUMP; any other -> TRAP.
- EXEC_R: ALUsrcA = 1, ALUsrcB = 00, ALUop = 100 -> WB_R.
- WB_R: reg_dst = 1, reg_write = 1, mem_to_reg = 0 -> FETCH.
- EXEC_I: ALUsrcA = 1, ALUsrcB = 10, extop = 0, ALUop = 010 -> WB_I.
- WB_I: reg_dst = 0, reg_write = 1 -> FETCH.
- MEM_ADDR: ALUsrcA = 1, ALUsrcB = 10, extop = 1, ALUop = 000. Go to MEM_RD if OP = LW, else MEM_WR.
- MEM_RD: mem_req = 1, IorD = 1. On mem_ack -> WB_MEM.
- WB_MEM: reg_dst = 0, mem_to_reg = 1, reg_write = 1 -> FETCH.
- MEM_WR: mem_req = 1, mem_write = 1, IorD = 1. On mem_ack -> FETCH.
- BRANCH: ALUsrcA = 1, ALUsrcB = 00, ALUop = 001, pc_write_cond = 1, pc_source = 01 -> FETCH.
- JUMP: pc_write = 1, pc_source = 10 -> FETCH.
- TRAP: fault = 1, all other outputs 0. Absorbing state; only reset exits.
- Wait counter:
  - Clears on entry to FETCH, MEM_RD and MEM_WR.
  - Increments each cycle mem_req = 1 and mem_ack = 0.
  - When the counter reaches MEM_WAIT_MAX with no ack -> TRAP.
  - An ack in the same cycle as the limit wins; no trap.
- mem_ack outside a memory state is ignored.
- Latency: R, ORI, BEQ, J take 4/4/3/3 cycles; LW takes 5 and SW takes 4 (zero-wait memory, FETCH included).

Optional Feature:
- Macro: MC_PERF_CNT_EN.
- When defined, adds outputs cyc_cnt[31:0] and instr_cnt[31:0], both reset to 0 and wrapping at 2^32.
  - cyc_cnt increments every cycle outside IDLE/TRAP.
  - instr_cnt increments on every transition into FETCH from a non-IDLE state.
- When undefined, these ports and registers are absent.

Decomposition:
- Shared package mc_pkg holds:
  - the state enum (4-bit encodings);
  - opcode constants OP_RTYPE, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_J;
  - ALUop codes ALU_ADD, ALU_SUB, ALU_OR, ALU_FUNCT;
  - ALUsrcB and pc_source encodings.
- One natural sub-module: mc_wait_timer (wait counter plus timeout compare).

Test Plan:
- Reset released, mem_ack tied 1, OP = 000000 -> state IDLE, FETCH, DECODE, EXEC_R, WB_R, FETCH; reg_write = 1 only in WB_R, with reg_dst = 1.
- OP = 100011, mem_ack delayed 3 cycles in MEM_RD -> mem_req/IorD held 3 extra cycles, then WB_MEM with mem_to_reg = 1 and reg_write = 1.
- OP = 101011 -> MEM_WR with mem_write = 1 and IorD = 1; reg_write is never asserted; back to FETCH after ack.
- OP = 000100 -> BRANCH with pc_write_cond = 1, ALUop = 001, pc_source = 01. OP = 000010 -> JUMP with pc_write = 1, pc_source = 10.
- OP = 111111 -> TRAP with fault = 1. Separately, mem_ack held 0 in FETCH for 15 cycles -> TRAP. Ack arriving at cycle 15 -> no trap. rst_n low -> IDLE, fault = 0.
- With MC_PERF_CNT_EN, 3 back-to-back ORI at zero wait -> instr_cnt = 3, cyc_cnt = 12 (IDLE excluded).
